// File: rtl/injection_pattern_checker.sv
// Stimulus driver and response checker for the fault-injection target (a..f -> y1/y2).
// Optional INJ_CHK_STOP_ON_FAIL_EN aborts a run at the first mismatching comparison.
module injection_pattern_checker #(
  parameter int          N_VECTORS = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y1,
  input  logic             y2,
  output logic [5:0]       stim,
  output logic             dut_rstn,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [15:0]      first_fail_idx
);
  localparam logic [15:0]      SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]      LAST_IDX = 16'(N_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, RESET, RUN, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic             rst_cnt_reg;
  logic [15:0]      lfsr_reg, lfsr_next;
  logic [15:0]      idx_reg;
  logic [5:0]       stim_reg;
  logic             g1_reg, g2_reg;
  logic             fail_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [15:0]      first_reg;
  logic             cmp_valid, mismatch, start_ok;

  // Galois LFSR, x^16+x^14+x^13+x^11+1; only steps while vectors are being applied
  always_comb begin
    lfsr_next = lfsr_reg;
    if (state_reg == RUN)
      lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);
  end

  // The response to vector idx-1 is visible one cycle after it was driven
  assign cmp_valid = ((state_reg == RUN) && (idx_reg != 16'd0)) || (state_reg == DRAIN);
  assign mismatch  = cmp_valid && ({y1, y2} != {g1_reg, g2_reg});
  assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    dut_rstn   = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = RESET;
      RESET: begin
        busy = 1'b1;
        if (rst_cnt_reg) state_next = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        dut_rstn = 1'b1;
        if (idx_reg == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        dut_rstn   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RESET : IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef INJ_CHK_STOP_ON_FAIL_EN
    if (mismatch) state_next = DONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt_reg <= 1'b0;
      lfsr_reg    <= SEED_EFF;
      idx_reg     <= 16'd0;
      stim_reg    <= 6'd0;
      g1_reg      <= 1'b0;
      g2_reg      <= 1'b0;
      fail_reg    <= 1'b0;
      cnt_reg     <= '0;
      first_reg   <= 16'd0;
    end else begin
      rst_cnt_reg <= (state_reg == RESET) ? ~rst_cnt_reg : 1'b0;
      // stim mirrors lfsr[5:0] throughout RUN and is zero in every other state
      stim_reg    <= (state_next == RUN) ? lfsr_next[5:0] : 6'd0;

      if (state_reg == RUN) begin
        g1_reg <= (g1_reg | stim_reg[0] | stim_reg[1]) & stim_reg[2];
        g2_reg <= (g2_reg | ~stim_reg[3]) & (stim_reg[4] | ~stim_reg[5]);
      end else if (state_reg == RESET) begin
        g1_reg <= 1'b0;
        g2_reg <= 1'b0;
      end

      if (start_ok) begin
        lfsr_reg  <= SEED_EFF;
        idx_reg   <= 16'd0;
        fail_reg  <= 1'b0;
        cnt_reg   <= '0;
        first_reg <= 16'd0;
      end else begin
        if (state_reg == RUN) begin
          lfsr_reg <= lfsr_next;
          idx_reg  <= idx_reg + 16'd1;
        end
        if (mismatch) begin
          if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
          fail_reg <= 1'b1;
          if (!fail_reg) first_reg <= idx_reg - 16'd1;
        end
      end
    end
  end

  assign stim           = stim_reg;
  assign fail           = fail_reg;
  assign mismatch_cnt   = cnt_reg;
  assign first_fail_idx = first_reg;

endmodule

// File: tb/tb_injection_pattern_checker.sv
// Bench for injection_pattern_checker: behavioural targets with injectable faults and an array-based reference.
module tb_injection_pattern_checker;
  localparam int N = 64;
`ifdef INJ_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start0 = 1'b0, start1 = 1'b0;

  // main instance
  logic y1_0, y2_0, rstn0, busy0, done0, fail0;
  logic [5:0] stim0;
  logic [7:0] cnt0;
  logic [15:0] ffi0;
  logic t1_0 = 1'b0, t2_0 = 1'b0, stuck1 = 1'b0, flip1 = 1'b0, flip2 = 1'b0;

  // seed-zero instance and saturating-counter instance
  logic y1_1, y2_1, rstn1, busy1, done1, fail1;
  logic [5:0] stim1;
  logic [7:0] cnt1;
  logic [15:0] ffi1;
  logic t1_1 = 1'b0, t2_1 = 1'b0;
  logic y1_2, y2_2, rstn2, busy2, done2, fail2;
  logic [5:0] stim2;
  logic [1:0] cnt2;
  logic [15:0] ffi2;
  logic t1_2 = 1'b0, t2_2 = 1'b0;

  injection_pattern_checker #(.N_VECTORS(N), .LFSR_SEED(16'hACE1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .y1(y1_0), .y2(y2_0), .stim(stim0), .dut_rstn(rstn0),
    .busy(busy0), .done(done0), .fail(fail0), .mismatch_cnt(cnt0), .first_fail_idx(ffi0));
  injection_pattern_checker #(.N_VECTORS(32), .LFSR_SEED(16'h0000), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .y1(y1_1), .y2(y2_1), .stim(stim1), .dut_rstn(rstn1),
    .busy(busy1), .done(done1), .fail(fail1), .mismatch_cnt(cnt1), .first_fail_idx(ffi1));
  injection_pattern_checker #(.N_VECTORS(16), .LFSR_SEED(16'hACE1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start1), .y1(y1_2), .y2(y2_2), .stim(stim2), .dut_rstn(rstn2),
    .busy(busy2), .done(done2), .fail(fail2), .mismatch_cnt(cnt2), .first_fail_idx(ffi2));

  // Targets: registered logic with synchronous active-low reset
  always @(posedge clk) begin
    if (!rstn0) begin t1_0 <= 1'b0; t2_0 <= 1'b0; end
    else begin
      t1_0 <= (t1_0 | stim0[0] | stim0[1]) & stim0[2];
      t2_0 <= (t2_0 | ~stim0[3]) & (stim0[4] | ~stim0[5]);
    end
    if (!rstn1) begin t1_1 <= 1'b0; t2_1 <= 1'b0; end
    else begin
      t1_1 <= (t1_1 | stim1[0] | stim1[1]) & stim1[2];
      t2_1 <= (t2_1 | ~stim1[3]) & (stim1[4] | ~stim1[5]);
    end
    if (!rstn2) begin t1_2 <= 1'b0; t2_2 <= 1'b0; end
    else begin
      t1_2 <= (t1_2 | stim2[0] | stim2[1]) & stim2[2];
      t2_2 <= (t2_2 | ~stim2[3]) & (stim2[4] | ~stim2[5]);
    end
  end
  assign y1_0 = stuck1 ? 1'b0 : (t1_0 ^ flip1);
  assign y2_0 = t2_0 ^ flip2;
  assign y1_1 = t1_1;
  assign y2_1 = t2_1;
  assign y1_2 = ~t1_2;  // permanently wrong: every comparison mismatches
  assign y2_2 = t2_2;

  int checks = 0, errors = 0;
  logic [5:0] vec [0:255];
  logic       g1r [0:255];
  logic       g2r [0:255];
  logic [5:0] stim_cap [0:255];
  logic       busy_cap [0:511];
  int         done_cyc;
  logic [7:0] res_cnt;
  logic [15:0] res_first;
  logic       res_fail, res_busy, res_rstn;
  logic [5:0] res_stim;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference: vector k is the seed stepped k times; g*r[k] is the target state after vector k
  task automatic build_ref(input logic [15:0] seed, input int n);
    logic [15:0] s;
    logic a, b;
    logic [5:0] v;
    s = (seed == 16'h0000) ? 16'h0001 : seed;
    a = 1'b0;
    b = 1'b0;
    for (int k = 0; k < n; k++) begin
      v = s[5:0];
      vec[k] = v;
      a = (a | v[0] | v[1]) & v[2];
      b = (b | ~v[3]) & (v[4] | ~v[5]);
      g1r[k] = a;
      g2r[k] = b;
      s = lfsr_step(s);
    end
  endtask

  task automatic run(input bit pre, input int flip_cyc, input logic [1:0] flip_mask,
                     input int rst_cyc, input int extra_start);
    done_cyc = -1;
    if (!pre) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      busy_cap[cyc] = busy0;
      if (cyc >= 3 && cyc < 3 + N) stim_cap[cyc-3] = stim0;
      if (done0) begin
        done_cyc  = cyc;
        res_cnt   = cnt0;
        res_first = ffi0;
        res_fail  = fail0;
        res_busy  = busy0;
        res_rstn  = rstn0;
        res_stim  = stim0;
        break;
      end
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        done_cyc = -2;
        break;
      end
      flip1  = (cyc == flip_cyc) && flip_mask[1];
      flip2  = (cyc == flip_cyc) && flip_mask[0];
      start0 = (cyc == extra_start);
      @(negedge clk);
    end
    flip1  = 1'b0;
    flip2  = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (stim0 !== 6'd0)  begin errors++; $display("FAIL reset_stim got=%0h exp=0", stim0); end
    checks++; if (rstn0 !== 1'b0)  begin errors++; $display("FAIL reset_dut_rstn got=%b exp=0", rstn0); end
    checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (done0 !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", done0); end
    checks++; if (fail0 !== 1'b0)  begin errors++; $display("FAIL reset_fail got=%b exp=0", fail0); end
    checks++; if (cnt0 !== 8'd0)   begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt0); end
    checks++; if (ffi0 !== 16'd0)  begin errors++; $display("FAIL reset_first got=%0d exp=0", ffi0); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_fault_free();
    int bad_stim, bad_busy;
    run(1'b0, -1, 2'b00, -1, -1);
    bad_stim = 0;
    bad_busy = 0;
    for (int k = 0; k < N; k++) if (stim_cap[k] !== vec[k]) bad_stim++;
    for (int c = 1; c <= N + 3; c++) if (busy_cap[c] !== 1'b1) bad_busy++;
    checks++; if (done_cyc != N + 4) begin errors++; $display("FAIL ff_done_cycle got=%0d exp=%0d", done_cyc, N + 4); end
    checks++; if (res_fail !== 1'b0) begin errors++; $display("FAIL ff_fail got=%b exp=0", res_fail); end
    checks++; if (res_cnt !== 8'd0)  begin errors++; $display("FAIL ff_cnt got=%0d exp=0", res_cnt); end
    checks++; if (bad_stim != 0)     begin errors++; $display("FAIL ff_stim_stream bad_vectors=%0d exp=0", bad_stim); end
    checks++; if (bad_busy != 0)     begin errors++; $display("FAIL ff_busy_window bad_cycles=%0d exp=0", bad_busy); end
    checks++; if (res_busy !== 1'b0 || res_rstn !== 1'b0 || res_stim !== 6'd0)
      begin errors++; $display("FAIL ff_done_idle got busy=%b rstn=%b stim=%0h exp 0/0/0", res_busy, res_rstn, res_stim); end
    $display("test_fault_free: done_cyc=%0d cnt=%0d", done_cyc, res_cnt);
  endtask

  task automatic test_back_to_back();
    // start is raised while done is high, so it is sampled in DONE
    run(1'b1, -1, 2'b00, -1, -1);
    checks++; if (busy_cap[1] !== 1'b1) begin errors++; $display("FAIL b2b_busy_cycle1 got=%b exp=1", busy_cap[1]); end
    checks++; if (done_cyc != N + 4)    begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=%0d", done_cyc, N + 4); end
    checks++; if (stim_cap[0] !== vec[0]) begin errors++; $display("FAIL b2b_vec0 got=%0h exp=%0h", stim_cap[0], vec[0]); end
    $display("test_back_to_back: done_cyc=%0d", done_cyc);
  endtask

  task automatic test_stuck_y1();
    int exp_cnt, exp_first;
    exp_cnt = 0;
    exp_first = 0;
    for (int k = N - 1; k >= 0; k--) if (g1r[k]) begin exp_cnt++; exp_first = k; end
    stuck1 = 1'b1;
    run(1'b0, -1, 2'b00, -1, -1);
    stuck1 = 1'b0;
    if (STOP && exp_cnt > 0) exp_cnt = 1;
    checks++; if (done_cyc != (STOP && exp_cnt > 0 ? exp_first + 5 : N + 4))
      begin errors++; $display("FAIL stuck_done_cycle got=%0d", done_cyc); end
    checks++; if (res_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL stuck_cnt got=%0d exp=%0d", res_cnt, exp_cnt); end
    checks++; if (res_first !== 16'(exp_first)) begin errors++; $display("FAIL stuck_first got=%0d exp=%0d", res_first, exp_first); end
    checks++; if (res_fail !== (exp_cnt > 0)) begin errors++; $display("FAIL stuck_fail got=%b exp=%b", res_fail, exp_cnt > 0); end
    checks++; if (res_rstn !== 1'b0) begin errors++; $display("FAIL stuck_done_rstn got=%b exp=0", res_rstn); end
    $display("test_stuck_y1: cnt=%0d first=%0d", res_cnt, res_first);
  endtask

  task automatic test_single_flip(input int k, input logic [1:0] mask);
    int exp_done;
    exp_done = STOP ? k + 5 : N + 4;
    run(1'b0, 4 + k, mask, -1, -1);
    checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL flip_done_cycle k=%0d got=%0d exp=%0d", k, done_cyc, exp_done); end
    checks++; if (res_cnt !== 8'd1) begin errors++; $display("FAIL flip_cnt k=%0d mask=%b got=%0d exp=1", k, mask, res_cnt); end
    checks++; if (res_first !== 16'(k)) begin errors++; $display("FAIL flip_first got=%0d exp=%0d", res_first, k); end
    checks++; if (res_fail !== 1'b1 || res_busy !== 1'b0)
      begin errors++; $display("FAIL flip_flags got fail=%b busy=%b exp 1/0", res_fail, res_busy); end
    $display("test_single_flip: k=%0d mask=%b done_cyc=%0d cnt=%0d first=%0d", k, mask, done_cyc, res_cnt, res_first);
  endtask

  task automatic test_random_flips();
    for (int i = 0; i < 4; i++)
      test_single_flip(int'($urandom_range(0, N - 1)), 2'($urandom_range(1, 3)));
  endtask

  task automatic test_start_while_busy();
    int bad_stim;
    run(1'b0, -1, 2'b00, -1, 30);
    bad_stim = 0;
    for (int k = 0; k < N; k++) if (stim_cap[k] !== vec[k]) bad_stim++;
    checks++; if (done_cyc != N + 4) begin errors++; $display("FAIL busy_start_done got=%0d exp=%0d", done_cyc, N + 4); end
    checks++; if (res_cnt !== 8'd0 || res_fail !== 1'b0)
      begin errors++; $display("FAIL busy_start_result got cnt=%0d fail=%b exp 0/0", res_cnt, res_fail); end
    checks++; if (bad_stim != 0) begin errors++; $display("FAIL busy_start_stim bad_vectors=%0d exp=0", bad_stim); end
    $display("test_start_while_busy: done_cyc=%0d", done_cyc);
  endtask

  task automatic test_mid_run_reset();
    int bad_stim;
    // an earlier fault (normal build only) leaves partial results to be discarded
    run(1'b0, STOP ? -1 : 9, 2'b11, 3 + 20, -1);
    checks++; if (busy0 !== 1'b0 || rstn0 !== 1'b0 || done0 !== 1'b0)
      begin errors++; $display("FAIL rst_mid_ctrl got busy=%b rstn=%b done=%b exp 0/0/0", busy0, rstn0, done0); end
    checks++; if (stim0 !== 6'd0) begin errors++; $display("FAIL rst_mid_stim got=%0h exp=0", stim0); end
    checks++; if (fail0 !== 1'b0 || cnt0 !== 8'd0 || ffi0 !== 16'd0)
      begin errors++; $display("FAIL rst_mid_results got fail=%b cnt=%0d first=%0d exp 0/0/0", fail0, cnt0, ffi0); end
    run(1'b0, -1, 2'b00, -1, -1);
    bad_stim = 0;
    for (int k = 0; k < N; k++) if (stim_cap[k] !== vec[k]) bad_stim++;
    checks++; if (bad_stim != 0) begin errors++; $display("FAIL rst_rerun_stim bad_vectors=%0d exp=0", bad_stim); end
    checks++; if (done_cyc != N + 4 || res_cnt !== 8'd0)
      begin errors++; $display("FAIL rst_rerun_result got done=%0d cnt=%0d exp %0d/0", done_cyc, res_cnt, N + 4); end
    $display("test_mid_run_reset: rerun done_cyc=%0d", done_cyc);
  endtask

  task automatic test_params();
    int bad_stim, d1, d2;
    logic [1:0] c2;
    logic f2, f1;
    logic [15:0] i2;
    build_ref(16'h0001, 32);
    bad_stim = 0;
    d1 = -1;
    d2 = -1;
    c2 = 2'd0; f2 = 1'b0; f1 = 1'b1; i2 = 16'hFFFF;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int cyc = 1; cyc < 100 && d1 < 0; cyc++) begin
      if (cyc >= 3 && cyc < 35 && stim1 !== vec[cyc-3]) bad_stim++;
      if (done1) begin d1 = cyc; f1 = fail1; end
      if (done2) begin d2 = cyc; c2 = cnt2; f2 = fail2; i2 = ffi2; end
      @(negedge clk);
    end
    checks++; if (bad_stim != 0) begin errors++; $display("FAIL seed0_stim bad_vectors=%0d exp=0", bad_stim); end
    checks++; if (d1 != 36 || f1 !== 1'b0) begin errors++; $display("FAIL seed0_done got cyc=%0d fail=%b exp 36/0", d1, f1); end
    checks++; if (d2 != (STOP ? 5 : 20)) begin errors++; $display("FAIL sat_done_cycle got=%0d exp=%0d", d2, STOP ? 5 : 20); end
    checks++; if (c2 !== (STOP ? 2'd1 : 2'd3)) begin errors++; $display("FAIL sat_cnt got=%0d exp=%0d", c2, STOP ? 1 : 3); end
    checks++; if (f2 !== 1'b1 || i2 !== 16'd0) begin errors++; $display("FAIL sat_flags got fail=%b first=%0d exp 1/0", f2, i2); end
    $display("test_params: seed0 done=%0d sat cnt=%0d", d1, c2);
  endtask

  initial begin
    build_ref(16'hACE1, N);
    test_reset();
    test_fault_free();
    test_back_to_back();
    test_stuck_y1();
    test_single_flip(10, 2'b01);
    test_single_flip(10, 2'b11);
    test_random_flips();
    test_start_while_busy();
    test_mid_run_reset();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
